// File: rtl/uart_arb_pkg.sv
// Shared types for the uart transmit arbiter: FSM state encoding and its width.
package uart_arb_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_c,
  output logic               found_c
);

  // Scan from ptr upwards; the first hit wins and masks the rest.
  always_comb begin
    int unsigned idx;
    logic [PTR_W-1:0] sel;
    pick_c  = '0;
    found_c = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!found_c && valid[sel]) begin
        pick_c[sel] = 1'b1;
        found_c     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among NUM_REQ requesters with round-robin
// selection and a per-message lock. Optional start timeout: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 transmit,
  output logic [7:0]           tx_byte,
  input  logic                 is_transmitting,
  output logic [NUM_REQ-1:0]   grant
`ifdef UART_ARB_TIMEOUT_EN
 ,output logic                 tx_error
`endif
);

  localparam int unsigned PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned BYTE_W = 8;

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                transmit_q, transmit_d;
  logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic                last_q, last_d;

  logic [NUM_REQ-1:0]  pick_c;
  logic                found_c;
  logic [NUM_REQ-1:0]  sel_c;
  logic                sel_valid_c;
  logic [BYTE_W-1:0]   sel_data_c;
  logic                sel_last_c;
  logic [PTR_W-1:0]    owner_idx_c;
  logic [PTR_W-1:0]    next_ptr_c;
  logic                done_c;
  logic                timeout_c;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .valid   (req_valid),
    .ptr     (rr_ptr_q),
    .pick_c  (pick_c),
    .found_c (found_c)
  );

  // Candidate: the locked owner if any, otherwise the round-robin pick.
  always_comb begin
    sel_c       = (|grant_q) ? grant_q : pick_c;
    sel_valid_c = |(sel_c & req_valid);
    sel_data_c  = '0;
    sel_last_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_c[i]) begin
        sel_data_c = sel_data_c | req_data[i*BYTE_W +: BYTE_W];
        sel_last_c = sel_last_c | req_last[i];
      end
    end
  end

  // Owner index and the pointer value that follows it.
  always_comb begin
    owner_idx_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner_idx_c = PTR_W'(i);
    end
    next_ptr_c = (owner_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(owner_idx_c + 1'b1);
  end

  assign done_c = (state_q == ST_WAIT_DONE) && !is_transmitting;

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_c = (state_q == ST_WAIT_START) && !is_transmitting &&
                     (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (sel_valid_c) state_d = ST_LOAD;
      ST_LOAD:       state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (is_transmitting) state_d = ST_WAIT_DONE;
        else if (timeout_c)  state_d = ST_IDLE;
      end
      ST_WAIT_DONE:  if (!is_transmitting) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    tx_byte_d   = tx_byte_q;
    last_d      = last_q;
    req_ready_d = '0;
    transmit_d  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    err_d    = err_q;
    to_cnt_d = (state_q == ST_WAIT_START) ? CNT_W'(to_cnt_q + 1'b1) : '0;
`endif
    if (state_q == ST_IDLE && sel_valid_c) begin
      grant_d     = sel_c;
      tx_byte_d   = sel_data_c;
      last_d      = sel_last_c;
      req_ready_d = sel_c;
    end
    if (state_q == ST_LOAD) transmit_d = 1'b1;
    if (done_c && last_q) begin
      grant_d  = '0;
      rr_ptr_d = next_ptr_c;
    end
    if (timeout_c) begin
      grant_d  = '0;
      rr_ptr_d = next_ptr_c;
`ifdef UART_ARB_TIMEOUT_EN
      err_d    = 1'b1;
`endif
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      tx_byte_q   <= '0;
      last_q      <= 1'b0;
      req_ready_q <= '0;
      transmit_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
`endif
    end else begin
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_byte_q   <= tx_byte_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
      transmit_q  <= transmit_d;
`ifdef UART_ARB_TIMEOUT_EN
      err_q       <= err_d;
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign transmit  = transmit_q;
  assign tx_byte   = tx_byte_q;
  assign grant     = grant_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign tx_error  = err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter; define UART_ARB_TIMEOUT_EN to cover the timeout.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*NR-1:0] req_data;
  logic            transmit, is_transmitting;
  logic [7:0]      tx_byte;
`ifdef UART_ARB_TIMEOUT_EN
  logic            tx_error;
`endif

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting),
    .grant           (grant)
`ifdef UART_ARB_TIMEOUT_EN
   ,.tx_error        (tx_error)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Requester message queues: {last, byte}.
  logic [8:0] rq [NR][$];
  int svc_idx[$], svc_byte[$], svc_cyc[$], tx_cyc[$];
  int exp_q[$];
  int cyc  = 0;
  int n_tx = 0;
  bit rst_req = 1'b1;
  bit uart_en = 1'b1;

  // Transaction-level model state.
  int         m_ptr, m_owner, ws_n, pw, u_dly, u_bsy;
  bit         m_idle, m_busy, m_in_ws, m_seen_rise, m_last, plast, pend_done, pend_to;
  logic [NR-1:0] exp_ready, exp_grant;
  logic       exp_tx, exp_err;
  logic [7:0] exp_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_list(input string name, input int act[$], input int exp[$]);
    chk({name, "_len"}, 32'(act.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk(name, 32'(act[i]), 32'(exp[i]));
  endtask

  // Spec rule: locked owner if any, else first valid at or after the pointer.
  function automatic int winner();
    if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (m_ptr + k) % NR;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; ws_n = 0; pw = 0;
    m_idle = 1; m_busy = 0; m_in_ws = 0; m_seen_rise = 0; m_last = 0; plast = 0;
    pend_done = 0; pend_to = 0;
    exp_ready = '0; exp_grant = '0; exp_tx = 0; exp_err = 0; exp_byte = '0;
  endtask

  // Single compare/drive process: check last edge, advance model, drive inputs, predict next edge.
  initial begin : cmp
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; is_transmitting = 1'b0;
    u_dly = 0; u_bsy = 0;
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("transmit",  32'(transmit),  32'(exp_tx));
      chk("grant",     32'(grant),     32'(exp_grant));
      chk("tx_byte",   32'(tx_byte),   32'(exp_byte));
`ifdef UART_ARB_TIMEOUT_EN
      chk("tx_error",  32'(tx_error),  32'(exp_err));
`endif
      for (int i = 0; i < NR; i++) if (req_ready[i]) begin svc_idx.push_back(i); svc_cyc.push_back(cyc); end
      if (transmit) begin svc_byte.push_back(int'(tx_byte)); tx_cyc.push_back(cyc); n_tx++; end

      if (!rst) begin
        if (exp_ready != '0) begin
          m_owner = pw; m_last = plast; void'(rq[pw].pop_front());
          m_busy = 1; m_idle = 0; m_in_ws = 0; m_seen_rise = 0; ws_n = 0;
        end
        if (exp_tx) m_in_ws = 1;
        if (pend_done) begin
          m_busy = 0; m_idle = 1; m_in_ws = 0; m_seen_rise = 0;
          if (m_last) begin m_ptr = (m_owner + 1) % NR; m_owner = -1; end
        end
        if (pend_to) begin
          m_busy = 0; m_idle = 1; m_in_ws = 0;
          m_ptr = (m_owner + 1) % NR; m_owner = -1;
        end
      end

      rst = rst_req;
      if (rst) begin u_dly = 0; u_bsy = 0; end
      else if (transmit && uart_en) begin u_dly = 1; u_bsy = 10; end
      if (u_dly > 0) begin u_dly--; is_transmitting = 1'b0; end
      else if (u_bsy > 0) begin u_bsy--; is_transmitting = 1'b1; end
      else is_transmitting = 1'b0;
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = rq[i].size() > 0;
        req_data[8*i +: 8] = req_valid[i] ? rq[i][0][7:0] : 8'h00;
        req_last[i] = req_valid[i] ? rq[i][0][8] : 1'b0;
      end

      if (rst) model_reset();
      else begin
        int w;
        exp_tx = (exp_ready != '0);
        exp_ready = '0; pend_done = 0; pend_to = 0;
        if (m_idle) begin
          w = winner();
          if (w >= 0) begin
            exp_ready = NR'(1) << w; pw = w;
            plast = rq[w][0][8]; exp_byte = rq[w][0][7:0];
          end
        end else if (m_busy && m_seen_rise) begin
          if (!is_transmitting) pend_done = 1;
        end else if (m_busy && m_in_ws) begin
          if (is_transmitting) m_seen_rise = 1;
`ifdef UART_ARB_TIMEOUT_EN
          else begin ws_n++; if (ws_n == TO) pend_to = 1; end
`endif
        end
        if (exp_ready != '0) exp_grant = exp_ready;
        else if ((pend_done && m_last) || pend_to) exp_grant = '0;
        else exp_grant = (m_owner >= 0) ? NR'(1) << m_owner : '0;
        if (pend_to) exp_err = 1'b1;
      end
    end
  end

  task automatic clear_logs();
    svc_idx.delete(); svc_byte.delete(); svc_cyc.delete(); tx_cyc.delete(); n_tx = 0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    bit q;
    q = 0;
    while (n < 2000) begin
      @(posedge clk); #2; n++;
      q = m_idle && !m_busy && exp_ready == '0;
      for (int i = 0; i < NR; i++) if (rq[i].size() != 0) q = 0;
      if (q) break;
    end
    chk("quiet_reached", 32'(q), 32'd1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rst_req = 1'b1;
    @(posedge clk); #2; rst_req = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_transmit", 32'(transmit), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    rst_req = 1'b0;

    // Single byte from requester 0.
    clear_logs();
    rq[0].push_back({1'b1, 8'h41});
    wait_quiet();
    exp_q = {0};    chk_list("single_order", svc_idx, exp_q);
    exp_q = {'h41}; chk_list("single_byte", svc_byte, exp_q);
    chk("single_latency", 32'(tx_cyc[0] - svc_cyc[0]), 32'd1);
    chk("single_grant_clear", 32'(grant), 32'd0);

    // Pointer now 1: simultaneous 0 and 1 serve 1 first.
    clear_logs();
    rq[0].push_back({1'b1, 8'h50});
    rq[1].push_back({1'b1, 8'h51});
    wait_quiet();
    exp_q = {1, 0}; chk_list("ptr1_order", svc_idx, exp_q);

    // Contention from reset.
    do_reset();
    clear_logs();
    rq[0].push_back({1'b1, 8'hA0});
    rq[0].push_back({1'b1, 8'hA4});
    rq[1].push_back({1'b1, 8'hA1});
    rq[2].push_back({1'b1, 8'hA2});
    rq[3].push_back({1'b1, 8'hA3});
    wait_quiet();
    exp_q = {0, 1, 2, 3, 0};                   chk_list("cont_order", svc_idx, exp_q);
    exp_q = {'hA0, 'hA1, 'hA2, 'hA3, 'hA4};    chk_list("cont_bytes", svc_byte, exp_q);
    chk("cont_tx_count", 32'(n_tx), 32'd5);

    // Packet lock: requester 1 waits for requester 2's whole message.
    do_reset();
    clear_logs();
    rq[2].push_back({1'b0, 8'h10});
    rq[2].push_back({1'b0, 8'h20});
    rq[2].push_back({1'b1, 8'h30});
    n = 0;
    while (grant !== 4'b0100 && n < 100) begin @(posedge clk); #2; n++; end
    chk("lock_granted", 32'(grant), 32'h4);
    rq[1].push_back({1'b1, 8'hB1});
    wait_quiet();
    exp_q = {2, 2, 2, 1};                 chk_list("lock_order", svc_idx, exp_q);
    exp_q = {'h10, 'h20, 'h30, 'hB1};     chk_list("lock_bytes", svc_byte, exp_q);

    // Wrap: requester 2 leaves pointer at 3, then 3 and 0 contend.
    clear_logs();
    rq[2].push_back({1'b1, 8'hC2});
    wait_quiet();
    clear_logs();
    rq[3].push_back({1'b1, 8'hC3});
    rq[0].push_back({1'b1, 8'hC0});
    wait_quiet();
    exp_q = {3, 0};           chk_list("wrap_order", svc_idx, exp_q);
    exp_q = {'hC3, 'hC0};     chk_list("wrap_bytes", svc_byte, exp_q);

    // Reset while the uart is busy.
    clear_logs();
    rq[1].push_back({1'b1, 8'hD1});
    n = 0;
    while (is_transmitting !== 1'b1 && n < 100) begin @(posedge clk); #2; n++; end
    chk("rstwd_busy_seen", 32'(is_transmitting), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_req = 1'b1;
    n_tx = 0;
    @(posedge clk); #2;
    chk("rstwd_grant", 32'(grant), 32'd0);
    chk("rstwd_ready", 32'(req_ready), 32'd0);
    chk("rstwd_transmit", 32'(transmit), 32'd0);
    chk("rstwd_tx_byte", 32'(tx_byte), 32'd0);
    rst_req = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("rstwd_no_tx", 32'(n_tx), 32'd0);
    clear_logs();
    rq[2].push_back({1'b1, 8'hE2});
    rq[1].push_back({1'b1, 8'hE1});
    wait_quiet();
    exp_q = {1, 2}; chk_list("rstwd_order", svc_idx, exp_q);

`ifdef UART_ARB_TIMEOUT_EN
    // Uart never starts: requester 1 times out, requester 2 is served next.
    do_reset();
    clear_logs();
    uart_en = 1'b0;
    rq[1].push_back({1'b1, 8'hF1});
    rq[2].push_back({1'b1, 8'hF2});
    n = 0;
    while (tx_error !== 1'b1 && n < 200) begin @(posedge clk); #2; n++; end
    chk("to_error", 32'(tx_error), 32'd1);
    chk("to_grant_clear", 32'(grant), 32'd0);
    uart_en = 1'b1;
    wait_quiet();
    exp_q = {1, 2}; chk_list("to_order", svc_idx, exp_q);
    chk("to_error_sticky", 32'(tx_error), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
